// File: rtl/cellrv32_package.sv
// Shared types for the CELLRV32 vector register file.
// The package deliberately holds no parameter-dependent types; widths stay
// module parameters so each instance can size itself.
package cellrv32_package;

  // Top-level controller phases: zeroing sweep, then normal operation.
  typedef enum logic {
    VRF_INIT = 1'b0,
    VRF_RUN  = 1'b1
  } vrf_state_t;

endpackage

// File: rtl/vrf_scoreboard.sv
// Per-register pending scoreboard for the vector register file.
// A reserve sets a bit and a commit clears it. A reserve and a commit to the
// same register in the same cycle leave the bit set. Updates are only
// accepted while en_i is high.
module vrf_scoreboard #(
  parameter int VREGS = 32,
  parameter int AW    = $clog2(VREGS)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             rsv_i,
  input  logic [AW-1:0]    rsv_addr_i,
  input  logic             clr0_i,
  input  logic [AW-1:0]    clr0_addr_i,
  input  logic             clr1_i,
  input  logic [AW-1:0]    clr1_addr_i,
  output logic [VREGS-1:0] pend_o
);

  logic [VREGS-1:0] r_pend;
  logic [VREGS-1:0] w_set;
  logic [VREGS-1:0] w_clr;
  logic [VREGS-1:0] w_pend_next;

  // Decode reserve/commit requests. The set mask is applied after the clear
  // mask so that the set wins.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (en_i) begin
      if (rsv_i)  w_set[rsv_addr_i]  = 1'b1;
      if (clr0_i) w_clr[clr0_addr_i] = 1'b1;
      if (clr1_i) w_clr[clr1_addr_i] = 1'b1;
    end
    w_pend_next = (r_pend & ~w_clr) | w_set;
  end

  // Register the pending bits.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_pend <= '0;
    else         r_pend <= w_pend_next;
  end

  assign pend_o = r_pend;

endmodule

// File: rtl/vrf_mp.sv
// Multi-port vector register file with two write ports, RD_PORTS registered
// read ports, per-element write enables, a post-reset zeroing sweep and a
// pending scoreboard.
// Optional macro VRF_BYPASS_EN: forward same-cycle write data to reads of the
// same register. Without it, such reads return the pre-write contents.
module vrf_mp
  import cellrv32_package::*;
#(
  parameter int VREGS      = 32,
  parameter int ELEMENTS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RD_PORTS   = 3,
  parameter int AW         = $clog2(VREGS)
) (
  input  logic                                                  clk_i,
  input  logic                                                  rstn_i,
  input  logic [RD_PORTS-1:0]                                   rd_req_i,
  input  logic [RD_PORTS-1:0][AW-1:0]                           rd_addr_i,
  output logic [RD_PORTS-1:0]                                   rd_valid_o,
  output logic [RD_PORTS-1:0][ELEMENTS-1:0][DATA_WIDTH-1:0]     rd_data_o,
  input  logic [ELEMENTS-1:0]                                   wr0_en_i,
  input  logic [AW-1:0]                                         wr0_addr_i,
  input  logic [ELEMENTS-1:0][DATA_WIDTH-1:0]                   wr0_data_i,
  input  logic                                                  wr0_commit_i,
  input  logic [ELEMENTS-1:0]                                   wr1_en_i,
  input  logic [AW-1:0]                                         wr1_addr_i,
  input  logic [ELEMENTS-1:0][DATA_WIDTH-1:0]                   wr1_data_i,
  input  logic                                                  wr1_commit_i,
  input  logic                                                  rsv_i,
  input  logic [AW-1:0]                                         rsv_addr_i,
  output logic [VREGS-1:0]                                      pend_o,
  output logic                                                  init_done_o
);

  typedef logic [ELEMENTS-1:0][DATA_WIDTH-1:0] vreg_t;

  vrf_state_t r_state;
  vrf_state_t w_state_next;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_next;
  logic w_run;

  // Flip-flop storage. It has no reset; the sweep clears it.
  vreg_t r_mem [VREGS];

  // FSM state and sweep counter registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= VRF_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state: sweep one register per cycle, leave INIT after the last one.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      VRF_INIT: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == AW'(VREGS - 1)) w_state_next = VRF_RUN;
      end
      default: ;
    endcase
  end

  assign w_run       = (r_state == VRF_RUN);
  assign init_done_o = w_run;

  // Storage update: zeroing sweep, or element-wise writes. Port 0 is applied
  // last so it wins on a same-element collision.
  always_ff @(posedge clk_i) begin
    if (!w_run) begin
      r_mem[r_cnt] <= '0;
    end else begin
      for (int k = 0; k < ELEMENTS; k++) begin
        if (wr1_en_i[k]) r_mem[wr1_addr_i][k] <= wr1_data_i[k];
        if (wr0_en_i[k]) r_mem[wr0_addr_i][k] <= wr0_data_i[k];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RD_PORTS; gi++) begin : gen_rd
      vreg_t w_rd_word;
      logic  r_valid;
      vreg_t r_data;

      // Select the word to return, optionally overlaid with this cycle's writes.
      always_comb begin
        w_rd_word = r_mem[rd_addr_i[gi]];
`ifdef VRF_BYPASS_EN
        for (int k = 0; k < ELEMENTS; k++) begin
          if (wr1_en_i[k] && (wr1_addr_i == rd_addr_i[gi])) w_rd_word[k] = wr1_data_i[k];
          if (wr0_en_i[k] && (wr0_addr_i == rd_addr_i[gi])) w_rd_word[k] = wr0_data_i[k];
        end
`endif
      end

      // Registered read port. Data holds when there is no request.
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else begin
          r_valid <= w_run & rd_req_i[gi];
          if (w_run && rd_req_i[gi]) r_data <= w_rd_word;
        end
      end

      assign rd_valid_o[gi] = r_valid;
      assign rd_data_o[gi]  = r_data;
    end
  endgenerate

  vrf_scoreboard #(
    .VREGS(VREGS),
    .AW   (AW)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_i       (w_run),
    .rsv_i      (rsv_i),
    .rsv_addr_i (rsv_addr_i),
    .clr0_i     (wr0_commit_i),
    .clr0_addr_i(wr0_addr_i),
    .clr1_i     (wr1_commit_i),
    .clr1_addr_i(wr1_addr_i),
    .pend_o     (pend_o)
  );

endmodule
